// File: rtl/downstream_vc_credit_manager.sv
// downstream_vc_credit_manager
//   Tracks availability of every downstream virtual channel of a router.
//   Each (port, vc) pair has a credit counter and a small ownership FSM
//   (IDLE -> ACTIVE -> DRAINING -> IDLE). Free VCs are handed out
//   round-robin per output port. Per-VC credit availability and idleness
//   go to the allocators.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   alloc_req_i/_grant_o/alloc_vc_o
//                       per-port VC request, same-cycle grant and granted VC
//   flit_sent_i/_vc_i/_tail_i
//                       flit forwarded downstream, its VC, and its tail marker
//   credit_i/credit_vc_i
//                       credit returned from downstream and its VC
//   credit_avail_o      VC is ACTIVE with at least one free slot
//   idle_vc_o           VC is IDLE (released and fully drained)
//   error_o             sticky protocol-violation flag
module downstream_vc_credit_manager #(
  parameter  int PORT_NUM    = 5,
  parameter  int VC_NUM      = 2,
  parameter  int BUFFER_SIZE = 8,
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUM-1:0]               alloc_req_i,
  output logic [PORT_NUM-1:0]               alloc_grant_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]  alloc_vc_o,
  input  logic [PORT_NUM-1:0]               flit_sent_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]  flit_vc_i,
  input  logic [PORT_NUM-1:0]               flit_tail_i,
  input  logic [PORT_NUM-1:0]               credit_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]  credit_vc_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]   credit_avail_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]   idle_vc_o,
  output logic                              error_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } vc_state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  vc_state_e                  state_q [PORT_NUM][VC_NUM];
  vc_state_e                  state_d [PORT_NUM][VC_NUM];
  logic [CNT_W-1:0]           cnt_q   [PORT_NUM][VC_NUM];
  logic [CNT_W-1:0]           cnt_d   [PORT_NUM][VC_NUM];
  logic [PORT_NUM-1:0][VC_SIZE-1:0] rr_q, rr_d;
  logic                       err_q, err_d;

  logic [PORT_NUM-1:0]              grant_s;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] grant_vc_s;

  // State register: FSMs, credit counters, round-robin pointers, error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          state_q[p][v] <= ST_IDLE;
          cnt_q[p][v]   <= CNT_FULL;
        end
      end
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  // Round-robin search for the first IDLE VC starting at rr_q, on registered
  // state only. Grants are suppressed while reset is asserted.
  always_comb begin
    grant_s    = '0;
    grant_vc_s = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        automatic int idx = (int'(rr_q[p]) + k) % VC_NUM;
        if (!grant_s[p] && alloc_req_i[p] && !rst && (state_q[p][idx] == ST_IDLE)) begin
          grant_s[p]    = 1'b1;
          grant_vc_s[p] = VC_SIZE'(idx);
        end else begin
          grant_s[p]    = grant_s[p];
          grant_vc_s[p] = grant_vc_s[p];
        end
      end
    end
  end

  // Next-state logic: counters, FSM transitions, pointer rotation, error.
  // Tail/drain transitions look at the counter's next value so a VC whose
  // last credit arrives together with the tail goes straight to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    err_d   = err_q;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (grant_s[p]) begin
        rr_d[p] = VC_SIZE'((int'(grant_vc_s[p]) + 1) % VC_NUM);
      end else begin
        rr_d[p] = rr_q[p];
      end
      for (int v = 0; v < VC_NUM; v++) begin
        automatic logic sent_s = flit_sent_i[p] && (int'(flit_vc_i[p]) == v);
        automatic logic cr_s   = credit_i[p] && (int'(credit_vc_i[p]) == v);
        case ({sent_s, cr_s})
          2'b10: begin
            if (cnt_q[p][v] == CNT_ZERO) begin
              err_d = 1'b1;
            end else begin
              cnt_d[p][v] = cnt_q[p][v] - CNT_W'(1);
            end
          end
          2'b01: begin
            if (cnt_q[p][v] == CNT_FULL) begin
              err_d = 1'b1;
            end else begin
              cnt_d[p][v] = cnt_q[p][v] + CNT_W'(1);
            end
          end
          default: cnt_d[p][v] = cnt_q[p][v];
        endcase
        // Only the owner of an ACTIVE VC may send on it.
        if (sent_s && (state_q[p][v] != ST_ACTIVE)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        case (state_q[p][v])
          ST_IDLE: begin
            if (grant_s[p] && (int'(grant_vc_s[p]) == v)) begin
              state_d[p][v] = ST_ACTIVE;
            end else begin
              state_d[p][v] = ST_IDLE;
            end
          end
          ST_ACTIVE: begin
            if (sent_s && flit_tail_i[p]) begin
              state_d[p][v] = (cnt_d[p][v] == CNT_FULL) ? ST_IDLE : ST_DRAIN;
            end else begin
              state_d[p][v] = ST_ACTIVE;
            end
          end
          ST_DRAIN: begin
            if (cnt_d[p][v] == CNT_FULL) begin
              state_d[p][v] = ST_IDLE;
            end else begin
              state_d[p][v] = ST_DRAIN;
            end
          end
          default: state_d[p][v] = ST_IDLE;
        endcase
      end
    end
  end

  // Output decode from registered state plus the combinational grant.
  always_comb begin
    alloc_grant_o  = grant_s;
    alloc_vc_o     = grant_vc_s;
    credit_avail_o = '0;
    idle_vc_o      = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        credit_avail_o[p][v] = (state_q[p][v] == ST_ACTIVE) && (cnt_q[p][v] != CNT_ZERO);
        idle_vc_o[p][v]      = (state_q[p][v] == ST_IDLE);
      end
    end
    error_o = err_q;
  end

endmodule

// File: tb/tb_downstream_vc_credit_manager.sv
module tb_downstream_vc_credit_manager;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int B  = 8;
  localparam int VS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [P-1:0]         alloc_req_i, alloc_grant_o, flit_sent_i, flit_tail_i, credit_i;
  logic [P-1:0][VS-1:0] alloc_vc_o, flit_vc_i, credit_vc_i;
  logic [P-1:0][V-1:0]  credit_avail_o, idle_vc_o;
  logic                 error_o;

  downstream_vc_credit_manager #(.PORT_NUM(P), .VC_NUM(V), .BUFFER_SIZE(B)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_grant_o(alloc_grant_o), .alloc_vc_o(alloc_vc_o),
    .flit_sent_i(flit_sent_i), .flit_vc_i(flit_vc_i), .flit_tail_i(flit_tail_i),
    .credit_i(credit_i), .credit_vc_i(credit_vc_i),
    .credit_avail_o(credit_avail_o), .idle_vc_o(idle_vc_o), .error_o(error_o)
  );

  typedef struct packed {
    logic [P-1:0]         grant;
    logic [P-1:0][VS-1:0] vc;
    logic [P-1:0][V-1:0]  avail;
    logic [P-1:0][V-1:0]  idle;
    logic                 err;
  } exp_t;

  exp_t sb_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Reference model: 0 = IDLE, 1 = ACTIVE (owned), 2 = DRAINING.
  int m_st  [P][V];
  int m_cnt [P][V];
  int m_rr  [P];
  bit m_err;

  function automatic void model_reset();
    for (int p = 0; p < P; p++) begin
      for (int v = 0; v < V; v++) begin
        m_st[p][v]  = 0;
        m_cnt[p][v] = B;
      end
      m_rr[p] = 0;
    end
    m_err = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares the DUT outputs of each cycle against the queued
  // expectation, sampled well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alloc_grant",  64'(alloc_grant_o),  64'(e.grant));
        chk("alloc_vc",     64'(alloc_vc_o),     64'(e.vc));
        chk("credit_avail", 64'(credit_avail_o), 64'(e.avail));
        chk("idle_vc",      64'(idle_vc_o),      64'(e.idle));
        chk("error",        64'(error_o),        64'(e.err));
      end
    end
  end

  // One stimulus cycle: random inputs (legal-only when requested), expected
  // outputs pushed to the scoreboard, then the model advanced past the edge.
  task automatic run_cycle(input bit do_rst, input bit legal);
    bit req [P];  bit snd [P]; bit tl [P]; bit cr [P];
    int fv  [P];  int cv  [P];
    bit g   [P];  int gv  [P];
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      req[p] = ($urandom_range(0, 2) == 0);
      fv[p]  = $urandom_range(0, V-1);
      cv[p]  = $urandom_range(0, V-1);
      tl[p]  = ($urandom_range(0, 3) == 0);
      if (legal) begin
        snd[p] = (m_st[p][fv[p]] == 1) && (m_cnt[p][fv[p]] > 0) && ($urandom_range(0, 1) == 1);
        cr[p]  = (m_cnt[p][cv[p]] < B) && ($urandom_range(0, 1) == 1);
      end else begin
        snd[p] = ($urandom_range(0, 3) == 0);
        cr[p]  = ($urandom_range(0, 3) == 0);
      end
      alloc_req_i[p] = req[p];
      flit_sent_i[p] = snd[p];
      flit_vc_i[p]   = VS'(fv[p]);
      flit_tail_i[p] = tl[p];
      credit_i[p]    = cr[p];
      credit_vc_i[p] = VS'(cv[p]);
    end
    rst = do_rst;
    if (do_rst) model_reset();

    e = '0;
    for (int p = 0; p < P; p++) begin
      g[p] = 1'b0; gv[p] = 0;
      if (!do_rst && req[p]) begin
        for (int k = 0; k < V; k++) begin
          int vv;
          vv = (m_rr[p] + k) % V;
          if (!g[p] && m_st[p][vv] == 0) begin
            g[p] = 1'b1; gv[p] = vv;
          end
        end
      end
      e.grant[p] = g[p];
      e.vc[p]    = VS'(gv[p]);
      for (int v = 0; v < V; v++) begin
        e.avail[p][v] = (m_st[p][v] == 1) && (m_cnt[p][v] > 0);
        e.idle[p][v]  = (m_st[p][v] == 0);
      end
    end
    e.err = m_err;
    sb_q.push_back(e);

    if (!do_rst) begin
      for (int p = 0; p < P; p++) begin
        for (int v = 0; v < V; v++) begin
          bit s, c;
          int nc, old;
          s   = snd[p] && (fv[p] == v);
          c   = cr[p] && (cv[p] == v);
          nc  = m_cnt[p][v];
          old = m_st[p][v];
          if (s && !c) begin
            if (nc == 0) m_err = 1'b1; else nc = nc - 1;
          end
          if (c && !s) begin
            if (nc == B) m_err = 1'b1; else nc = nc + 1;
          end
          if (s && old != 1) m_err = 1'b1;
          m_cnt[p][v] = nc;
          if (old == 0 && g[p] && gv[p] == v) m_st[p][v] = 1;
          else if (old == 1 && s && tl[p])    m_st[p][v] = (nc == B) ? 0 : 2;
          else if (old == 2 && nc == B)       m_st[p][v] = 0;
        end
        if (g[p]) m_rr[p] = (gv[p] + 1) % V;
      end
    end
  endtask

  initial begin
    alloc_req_i = '0; flit_sent_i = '0; flit_vc_i = '0; flit_tail_i = '0;
    credit_i = '0; credit_vc_i = '0;
    model_reset();
    repeat (2) run_cycle(1'b1, 1'b1);
    repeat (400) run_cycle(1'b0, 1'b1);
    run_cycle(1'b1, 1'b1);               // asynchronous reset mid-traffic
    repeat (400) run_cycle(1'b0, 1'b1);
    repeat (300) run_cycle(1'b0, 1'b0);  // includes protocol violations
    run_cycle(1'b1, 1'b0);
    repeat (60) run_cycle(1'b0, 1'b0);
    @(negedge clk);
    alloc_req_i = '0; flit_sent_i = '0; credit_i = '0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
